// File: rtl/fourbytememory_arbiter_pkg.sv
// Shared definitions for the four-byte memory arbiter.
//   - DATA_W_DEF / ADR_W_DEF : default word and address widths
//   - state_t                : transaction FSM states (IDLE -> ISSUE -> COMPLETE)
package fourbytememory_arbiter_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADR_W_DEF  = 2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      COMPLETE = 2'd2
   } state_t;

endpackage

// File: rtl/fourbytememory_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the four-byte memory.
//   requester side : a_/b_ req, wr, adr, wdata (in) ; gnt, ack (out) ; rdata (out)
//   memory side    : mem_en, mem_wr, mem_adr, mem_data (out) ; mem_out (in)
// Handshake: a requester raises req and keeps wr/adr/wdata stable until the
// arbiter samples it in IDLE. From then on the transaction is committed:
// gnt is high for the ISSUE and COMPLETE cycles, and ack pulses for one
// cycle in COMPLETE, when rdata is valid for reads. A req still high after
// ack counts as a fresh request.
// Modports: slave = arbiter view, master = requesters plus memory view.
interface fourbytememory_arbiter_if
   import fourbytememory_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADR_W  = ADR_W_DEF
) ();

   logic              a_req,   b_req;
   logic              a_wr,    b_wr;
   logic [ADR_W-1:0]  a_adr,   b_adr;
   logic [DATA_W-1:0] a_wdata, b_wdata;
   logic              a_gnt,   b_gnt;
   logic              a_ack,   b_ack;
   logic [DATA_W-1:0] rdata;
   logic              mem_en,  mem_wr;
   logic [ADR_W-1:0]  mem_adr;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] mem_out;

   modport slave (
      input  a_req, b_req, a_wr, b_wr, a_adr, b_adr, a_wdata, b_wdata, mem_out,
      output a_gnt, b_gnt, a_ack, b_ack, rdata, mem_en, mem_wr, mem_adr, mem_data
   );

   modport master (
      output a_req, b_req, a_wr, b_wr, a_adr, b_adr, a_wdata, b_wdata, mem_out,
      input  a_gnt, b_gnt, a_ack, b_ack, rdata, mem_en, mem_wr, mem_adr, mem_data
   );

endinterface

// File: rtl/fourbytememory_arbiter_rr_arb2.sv
// Two-way round-robin choice (combinational).
//   req[0]=A, req[1]=B ; ptr=0 favours A, ptr=1 favours B
//   gnt : one-hot winner, zero when nobody requests
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      // Only a tie consults the pointer; a lone requester always wins.
      if (req == 2'b11) begin
         gnt = ptr ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/fourbytememory_arbiter.sv
// Arbiter giving two requesters shared access to a four-byte memory.
// Each transaction takes IDLE -> ISSUE -> COMPLETE (one access per 3 cycles).
//   clk, rst  : system clock, synchronous active-high reset
//   bus       : requester and memory signals (slave modport)
//   state_dbg : current FSM state
module fourbytememory_arbiter
   import fourbytememory_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADR_W  = ADR_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   fourbytememory_arbiter_if.slave    bus,
   output state_t                     state_dbg
);

   state_t            state, state_nxt;
   logic              ptr;        // 0 favours A, 1 favours B
   logic [1:0]        owner;      // one-hot winner of the current transaction
   logic              wr_l;
   logic [ADR_W-1:0]  adr_l;
   logic [DATA_W-1:0] wdata_l;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        req_vec, win, gnt, ack;
   logic              mem_en, mem_wr;

   assign req_vec = {bus.b_req, bus.a_req};

   rr_arb2 u_arb (
      .req (req_vec),
      .ptr (ptr),
      .gnt (win)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      gnt       = 2'b00;
      ack       = 2'b00;
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      case (state)
         IDLE: begin
            if (|req_vec) state_nxt = ISSUE;
         end
         ISSUE: begin
            gnt       = owner;
            mem_en    = 1'b1;
            mem_wr    = wr_l;
            state_nxt = COMPLETE;
         end
         COMPLETE: begin
            gnt       = owner;
            // A reset arriving in this cycle aborts the transaction, so the
            // ack must already be suppressed here.
            ack       = owner & {2{~rst}};
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, read capture and pointer update.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr     <= 1'b0;
         owner   <= 2'b00;
         wr_l    <= 1'b0;
         adr_l   <= '0;
         wdata_l <= '0;
         rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req_vec) begin
                  owner   <= win;
                  wr_l    <= win[1] ? bus.b_wr    : bus.a_wr;
                  adr_l   <= win[1] ? bus.b_adr   : bus.a_adr;
                  wdata_l <= win[1] ? bus.b_wdata : bus.a_wdata;
               end
            end
            ISSUE: begin
               if (!wr_l) rdata_q <= bus.mem_out;
            end
            COMPLETE: begin
               // Favour the loser next: A just won -> ptr=1, B just won -> ptr=0.
               ptr <= owner[0];
            end
            default: ;
         endcase
      end
   end

   assign bus.a_gnt    = gnt[0];
   assign bus.b_gnt    = gnt[1];
   assign bus.a_ack    = ack[0];
   assign bus.b_ack    = ack[1];
   assign bus.mem_en   = mem_en;
   assign bus.mem_wr   = mem_wr;
   assign bus.mem_adr  = adr_l;
   assign bus.mem_data = wdata_l;
   assign bus.rdata    = rdata_q;
   assign state_dbg    = state;

endmodule

// File: doc/fourbytememory_arbiter.md
FOURBYTEMEMORY_ARBITER -- requirements
Module: fourbytememory_arbiter

Interface
REQ-001 Parameter: DATA_W, default 8, memory word width in bits.
REQ-002 Parameter: ADR_W, default 2, memory address width in bits (4 locations).
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a_req, b_req  input  1 each  access request from requester A / B.
REQ-006 a_wr, b_wr  input  1 each  1 = write, 0 = read.
REQ-007 a_adr, b_adr  input  ADR_W each  target byte address.
REQ-008 a_wdata, b_wdata  input  DATA_W each  write data.
REQ-009 a_gnt, b_gnt  output  1 each  requester owns the memory for the current transaction.
REQ-010 a_ack, b_ack  output  1 each  one-cycle completion pulse.
REQ-011 rdata  output  DATA_W  read data shared by both requesters.
REQ-012 mem_en, mem_wr  output  1 each  memory enable and write strobe.
REQ-013 mem_adr  output  ADR_W  memory address.
REQ-014 mem_data  output  DATA_W  memory write data.
REQ-015 mem_out  input  DATA_W  memory read data; combinational from mem_adr while mem_en=1.

Function
REQ-016 FSM states: IDLE, ISSUE, COMPLETE; every transaction SHALL visit all three in order.
REQ-017 IDLE: with any req high at the edge, choose the winner, latch its wr/adr/wdata, move to ISSUE; with no req, stay in IDLE.
REQ-018 Arbitration: round-robin; a 1-bit priority pointer names the favoured requester; a lone requester always wins.
REQ-019 ISSUE: mem_en=1, mem_wr/mem_adr/mem_data from the latch for exactly one cycle; on reads, mem_out SHALL be captured into rdata at the edge ending ISSUE; always move to COMPLETE.
REQ-020 COMPLETE: mem_en=0; the winner's ack=1 for this cycle only; the pointer SHALL flip to the loser; move to IDLE.
REQ-021 Timing: req sampled in IDLE at cycle 0 -> gnt high cycles 1-2, mem_en high cycle 1, ack cycle 2, next arbitration at cycle 3; peak throughput one access per 3 cycles.
REQ-022 gnt SHALL be one-hot or zero; ack SHALL only go high together with the same requester's gnt.
REQ-023 rdata SHALL hold its value until the next read's COMPLETE; writes SHALL NOT change rdata.
REQ-024 A transaction is committed once ISSUE is entered; dropping req or changing req inputs afterwards SHALL NOT abort or alter it.
REQ-025 A req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-026 mem_en=0, mem_wr=0 in IDLE and COMPLETE; mem_adr/mem_data SHALL hold the latched values.

Reset
REQ-027 When rst=1 at an edge: state=IDLE, pointer favours A, gnt/ack/mem_en/mem_wr=0, mem_adr=0, mem_data=0, rdata=0.
REQ-028 rst asserted during ISSUE or COMPLETE SHALL abort the transaction with no ack; rst has priority over all requests.

Structure
REQ-029 The shared package SHALL hold the state enumeration (IDLE/ISSUE/COMPLETE) and the DATA_W/ADR_W defaults.
REQ-030 The round-robin choice SHALL be one sub-module, rr_arb2 (inputs: two reqs, pointer; output: one-hot grant).
REQ-031 The block SHALL connect directly to the existing four-byte memory through the mem_* ports, with no added glue logic.

Verification
REQ-032 Write then read:
  - A writes 0x5A to adr 2 (mem_wr=1 cycle 1, a_ack cycle 2).
  - A then reads adr 2 -> rdata=0x5A with a_ack.
REQ-033 Simultaneous reads after reset:
  - a_req and b_req high at once -> A served first, B next.
  - b_gnt rises exactly 3 cycles after a_gnt.
REQ-034 Fairness:
  - Both reqs held high for 12 cycles -> grants alternate A,B,A,B.
  - No ack from both requesters in the same cycle.
REQ-035 Mid-transaction changes:
  - Drop a_req in ISSUE -> a_ack still pulses in the next cycle.
  - Change a_adr 0->3 during ISSUE -> memory still accesses adr 0.
REQ-036 Reset mid-transaction:
  - rst in COMPLETE -> no ack, rdata=0, mem_en=0.
  - Next simultaneous request -> A wins.
REQ-037 Read data hold:
  - B reads 0xC3 from adr 1, then A writes 0x00 to adr 1.
  - rdata stays 0xC3 until the next read completes.
